// File: rtl/alu_sequencer_if.sv
// Instruction-source and ALU signals of the ALU sequencer, bundled for the sequencer port.
// Handshake: start is an instruction-valid strobe that the sequencer samples only while busy=0.
// busy is its "not ready" flag. done (with err) pulses for one cycle when the instruction retires.
interface alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int RSEL_W = 3
);
    logic              start;
    logic [3:0]        op_in;
    logic [RSEL_W-1:0] rx_in;
    logic [RSEL_W-1:0] ry_in;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        alu_ins;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output start, op_in, rx_in, ry_in, data_in, alu_result,
        input  busy, done, err, alu_ins, alu_a, alu_b
    );

    modport slave (
        input  start, op_in, rx_in, ry_in, data_in, alu_result,
        output busy, done, err, alu_ins, alu_a, alu_b
    );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer and register bank for the 16-bit ALU. It decodes one instruction per
// handshake, drives the ALU and writes the result back. MINALL scans every register through the ALU.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int RSEL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_sequencer_if.slave    bus,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MA_LOOP = 2'd2,
        WB      = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_MOV    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_MIN    = 4'b0100;
    localparam logic [3:0] OP_MINALL = 4'b0111;
    localparam logic [RSEL_W-1:0] LAST_IDX = RSEL_W'(NREGS - 1);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        op_q;
    logic [RSEL_W-1:0] rx_q;
    logic [RSEL_W-1:0] ry_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] acc;
    logic [RSEL_W-1:0] idx;
    logic              illegal;

    assign illegal   = !(op_q inside {OP_LOAD, OP_MOV, OP_ADD, OP_XOR, OP_MIN, OP_MINALL});
    assign bus.busy  = (state != IDLE);
    assign dbg_data  = regs[dbg_sel];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The ALU is only driven in EXEC and MA_LOOP; elsewhere it sees a quiet all-zero bus.
    always_comb begin
        state_nx    = state;
        bus.alu_ins = 4'b0000;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.op_in == OP_MINALL) ? MA_LOOP : EXEC;
                end
            end
            EXEC: begin
                bus.alu_ins = op_q;
                bus.alu_a   = regs[rx_q];
                bus.alu_b   = regs[ry_q];
                state_nx    = WB;
            end
            MA_LOOP: begin
                bus.alu_ins = OP_MINALL;
                bus.alu_a   = acc;
                bus.alu_b   = regs[idx];
                if (idx == LAST_IDX) begin
                    state_nx = WB;
                end
            end
            WB: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            op_q     <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            data_q   <= '0;
            res      <= '0;
            acc      <= '0;
            idx      <= '0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op_in;
                        rx_q   <= bus.rx_in;
                        ry_q   <= bus.ry_in;
                        data_q <= bus.data_in;
                        if (bus.op_in == OP_MINALL) begin
                            acc <= regs[0];
                            idx <= RSEL_W'(1);
                        end
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_LOAD: res <= data_q;
                        OP_MOV:  res <= regs[ry_q];
                        default: res <= bus.alu_result;
                    endcase
                end
                MA_LOOP: begin
                    acc <= bus.alu_result;
                    if (idx == LAST_IDX) begin
                        res <= bus.alu_result;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WB: begin
                    // Illegal opcodes still retire (done+err) but leave the bank untouched.
                    if (!illegal) begin
                        regs[rx_q] <= res;
                    end
                    bus.done <= 1'b1;
                    bus.err  <= illegal;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU, instruction driver tasks and an expected queue
// of write-back values checked on each done pulse.
module tb_alu_sequencer;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int RSEL_W = 3;

    localparam logic [3:0] LOAD   = 4'b0000;
    localparam logic [3:0] MOV    = 4'b0001;
    localparam logic [3:0] ADD    = 4'b0010;
    localparam logic [3:0] XOR_OP = 4'b0011;
    localparam logic [3:0] MIN    = 4'b0100;
    localparam logic [3:0] MINALL = 4'b0111;

    logic              clk;
    logic              reset;
    logic [RSEL_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;
    logic [1:0]        fsm_state;

    logic [DATA_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer_if #(.DATA_W(DATA_W), .RSEL_W(RSEL_W)) bus ();

    alu_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS), .RSEL_W(RSEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (bus.alu_ins)
            ADD:         bus.alu_result = bus.alu_a + bus.alu_b;
            XOR_OP:      bus.alu_result = bus.alu_a ^ bus.alu_b;
            MIN, MINALL: bus.alu_result = (bus.alu_a < bus.alu_b) ? bus.alu_a : bus.alu_b;
            default:     bus.alu_result = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input int r, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        dbg_sel = RSEL_W'(r);
        #1;
        check_eq($sformatf("%s_R%0d", tag, r), 32'(dbg_data), 32'(exp));
    endtask

    // Issue one instruction and follow it to its done pulse. With poke set, a LOAD R0=AAAA
    // is presented while the sequencer is busy and must be ignored.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [RSEL_W-1:0] rx,
                         input logic [RSEL_W-1:0] ry, input logic [DATA_W-1:0] data,
                         input logic [DATA_W-1:0] exp_val, input int exp_lat,
                         input logic exp_err, input bit poke);
        int lat;
        bit seen;
        logic [DATA_W-1:0] wb_val;
        logic [DATA_W-1:0] exp_wb;
        logic err_v;
        logic [3:0] ins_v;
        logic busy_v;
        lat = 0;
        seen = 0;
        wb_val = '0;
        err_v = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op_in   = op;
        bus.rx_in   = rx;
        bus.ry_in   = ry;
        bus.data_in = data;
        dbg_sel     = rx;
        exp_q.push_back(exp_val);
        @(posedge clk);
        #1;
        ins_v  = bus.alu_ins;
        busy_v = bus.busy;
        @(negedge clk);
        bus.start = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 2) begin
                bus.start   = 1'b1;
                bus.op_in   = LOAD;
                bus.rx_in   = '0;
                bus.data_in = 16'hAAAA;
            end else if (poke && lat == 3) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen   = 1;
                wb_val = dbg_data;
                err_v  = bus.err;
            end
        end
        exp_wb = exp_q.pop_front();
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_wb"}, 32'(wb_val), 32'(exp_wb));
        check_eq({tag, "_err"}, 32'(err_v), 32'(exp_err));
        check_eq({tag, "_ins"}, 32'(ins_v), 32'((op == MINALL) ? 4'b0111 : op));
        check_eq({tag, "_busy"}, 32'(busy_v), 32'd1);
    endtask

    initial begin
        logic [DATA_W-1:0] vals [NREGS];
        logic [DATA_W-1:0] after_ma [NREGS];
        bit done_seen;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op_in = '0;
        bus.rx_in = '0;
        bus.ry_in = '0;
        bus.data_in = '0;
        dbg_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_ins", 32'(bus.alu_ins), 32'd0);
        check_eq("rst_a", 32'(bus.alu_a), 32'd0);
        check_eq("rst_b", 32'(bus.alu_b), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) check_reg("rst", i, '0);

        // LOAD and ADD; back-to-back starts land in the done cycle of the previous op
        do_op("ld_r1", LOAD, 3'd1, 3'd0, 16'h0005, 16'h0005, 2, 1'b0, 0);
        do_op("ld_r2", LOAD, 3'd2, 3'd0, 16'h0003, 16'h0003, 2, 1'b0, 0);
        do_op("add", ADD, 3'd1, 3'd2, 16'h0000, 16'h0008, 2, 1'b0, 0);

        // ADD wraps, XOR
        do_op("ld_r1b", LOAD, 3'd1, 3'd0, 16'hFFFF, 16'hFFFF, 2, 1'b0, 0);
        do_op("ld_r2b", LOAD, 3'd2, 3'd0, 16'h0002, 16'h0002, 2, 1'b0, 0);
        do_op("add_wrap", ADD, 3'd1, 3'd2, 16'h0000, 16'h0001, 2, 1'b0, 0);
        do_op("ld_r3", LOAD, 3'd3, 3'd0, 16'hFFFF, 16'hFFFF, 2, 1'b0, 0);
        do_op("ld_r4", LOAD, 3'd4, 3'd0, 16'h00FF, 16'h00FF, 2, 1'b0, 0);
        do_op("xor", XOR_OP, 3'd3, 3'd4, 16'h0000, 16'hFF00, 2, 1'b0, 0);

        // Unsigned MIN, MOV
        do_op("ld_r5", LOAD, 3'd5, 3'd0, 16'h8000, 16'h8000, 2, 1'b0, 0);
        do_op("ld_r6", LOAD, 3'd6, 3'd0, 16'h7FFF, 16'h7FFF, 2, 1'b0, 0);
        do_op("min", MIN, 3'd5, 3'd6, 16'h0000, 16'h7FFF, 2, 1'b0, 0);
        do_op("mov", MOV, 3'd0, 3'd5, 16'h0000, 16'h7FFF, 2, 1'b0, 0);

        // rx == ry
        do_op("add_self", ADD, 3'd4, 3'd4, 16'h0000, 16'h01FE, 2, 1'b0, 0);
        do_op("xor_self", XOR_OP, 3'd3, 3'd3, 16'h0000, 16'h0000, 2, 1'b0, 0);
        do_op("min_self", MIN, 3'd4, 3'd4, 16'h0000, 16'h01FE, 2, 1'b0, 0);

        // MINALL: seven loop cycles plus write-back from the start edge to done
        vals = '{16'd9, 16'd4, 16'd7, 16'd2, 16'd8, 16'd6, 16'd5, 16'd3};
        for (int i = 0; i < NREGS; i++)
            do_op($sformatf("ma_ld%0d", i), LOAD, RSEL_W'(i), 3'd0, vals[i], vals[i], 2, 1'b0, 0);
        do_op("minall", MINALL, 3'd6, 3'd0, 16'h0000, 16'h0002, NREGS, 1'b0, 0);
        do_op("minall_poke", MINALL, 3'd7, 3'd0, 16'h0000, 16'h0002, NREGS, 1'b0, 1);
        after_ma = '{16'd9, 16'd4, 16'd7, 16'd2, 16'd8, 16'd6, 16'd2, 16'd2};
        for (int i = 0; i < NREGS; i++) check_reg("busy_start", i, after_ma[i]);
        do_op("ld_r7", LOAD, 3'd7, 3'd0, 16'h0001, 16'h0001, 2, 1'b0, 0);
        do_op("minall_last", MINALL, 3'd0, 3'd0, 16'h0000, 16'h0001, NREGS, 1'b0, 0);

        // Reset during MINALL loop cycle 4
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_in = MINALL;
        bus.rx_in = 3'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1;
        end
        check_eq("abort_no_done", 32'(done_seen), 32'd0);
        for (int i = 0; i < NREGS; i++) check_reg("abort", i, '0);
        do_op("ld_after_rst", LOAD, 3'd3, 3'd0, 16'h1234, 16'h1234, 2, 1'b0, 0);

        // Illegal opcodes retire with err and leave the destination alone
        do_op("ld_r2c", LOAD, 3'd2, 3'd0, 16'h55AA, 16'h55AA, 2, 1'b0, 0);
        do_op("ill_0101", 4'b0101, 3'd2, 3'd3, 16'h1111, 16'h55AA, 2, 1'b1, 0);
        do_op("ill_1000", 4'b1000, 3'd2, 3'd3, 16'h2222, 16'h55AA, 2, 1'b1, 0);
        do_op("legal_after", LOAD, 3'd2, 3'd0, 16'h0007, 16'h0007, 2, 1'b0, 0);
        check_reg("final", 3, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
